// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, baud divisor helper, FSM state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Used by esp_uart_tx and intended for the matching receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Line-bit phases of a frame. The S_ prefix keeps the PARITY state from
  // colliding with the PARITY parameter of modules that import this package.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

  // Clock cycles per line bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output and occupancy count.
// Latency: a pushed entry is visible on head the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: push/push_data write side; pop consumes head; count/full/empty report
// occupancy. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/esp_uart_tx.sv
// Buffered UART transmitter (8N1/8E1/8O1, 1 or 2 stop bits) for the ESP link line.
// Latency: byte accepted into an empty, idle block -> start bit on the next edge.
// Backpressure: in_ready drops while the FIFO holds FIFO_DEPTH bytes.
// Ports: in_data/in_valid/in_ready byte stream in; txd serial out (idle high);
// busy = frame in flight or bytes queued; fifo_count = queued bytes.
module esp_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_chk
    $error("esp_uart_tx: CLK_HZ/BAUD gives fewer than 2 cycles per bit");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("esp_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("esp_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("esp_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shreg;
  logic          par_bit;

  logic [7:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          baud_last;
  logic          stop_last;

  assign in_ready  = ~fifo_full;
  assign push      = in_valid & in_ready & ~reset;
  assign baud_last = (baud_cnt == BW'(DIV - 1));
  assign stop_last = (stop_idx == 1'(STOP_BITS - 1));

  // The head is taken either from idle or on the very last cycle of the last
  // stop bit, which chains frames with no idle gap.
  assign pop = ~fifo_empty &
               ((state == S_IDLE) | ((state == S_STOP) & baud_last & stop_last));

  assign busy = (state != S_IDLE) | ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shreg    <= head;
            // Parity is fixed at load time; the shift register is consumed later.
            par_bit  <= (PARITY == PARITY_ODD) ? ~^head : ^head;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            txd      <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            txd   <= shreg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            if (bit_idx == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                txd   <= par_bit;
                state <= S_PARITY;
              end else begin
                txd      <= 1'b1;
                stop_idx <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (baud_last) begin
            txd      <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            if (stop_last) begin
              if (pop) begin
                shreg    <= head;
                par_bit  <= (PARITY == PARITY_ODD) ? ~^head : ^head;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                txd      <= 1'b0;
                state    <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_esp_uart_tx.sv
// Self-checking bench for esp_uart_tx: three instances (8N1, 8E1, 8O2) at 10 cycles/bit.
// Reference: per-instance byte queue plus current-frame bit vector, advanced once per clock.
// Every cycle txd, fifo_count, busy and in_ready are compared with the reference.
module tb_esp_uart_tx;

  localparam int DIVT = 10;

  logic       clk;
  logic       reset;
  logic [7:0] din [3];
  logic [2:0] vin;
  logic [2:0] rdy;
  logic [2:0] txd;
  logic [2:0] busy;
  logic [4:0] cnt [3];

  int total = 0;
  int bad   = 0;

  // Reference state
  int         nbits [3] = '{10, 11, 12};
  logic [7:0] fq    [3][64];
  int         hd    [3];
  int         tl    [3];
  bit         act   [3];
  int         pos   [3];
  logic [11:0] fbits [3];
  logic [2:0] last_acc;

  esp_uart_tx #(.CLK_HZ(1000), .BAUD(100), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_n1 (
    .clk(clk), .reset(reset), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
    .txd(txd[0]), .busy(busy[0]), .fifo_count(cnt[0]));

  esp_uart_tx #(.CLK_HZ(1000), .BAUD(100), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_e1 (
    .clk(clk), .reset(reset), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
    .txd(txd[1]), .busy(busy[1]), .fifo_count(cnt[1]));

  esp_uart_tx #(.CLK_HZ(1000), .BAUD(100), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_o2 (
    .clk(clk), .reset(reset), .in_data(din[2]), .in_valid(vin[2]), .in_ready(rdy[2]),
    .txd(txd[2]), .busy(busy[2]), .fifo_count(cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%0h exp=%0h t=%0t", tag, k, got, exp, $time);
    end
  endtask

  // Line image of one frame: start, data LSB first, optional parity, stop bits (all ones above).
  function automatic logic [11:0] mk_frame(input int k, input logic [7:0] b);
    logic [11:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    if (k == 1) f[9] = (ones % 2 == 1) ? 1'b1 : 1'b0;
    if (k == 2) f[9] = (ones % 2 == 1) ? 1'b0 : 1'b1;
    return f;
  endfunction

  // One clock: sample handshakes before the edge, advance the reference, check all outputs.
  task automatic tick();
    logic [2:0] acc;
    logic [7:0] ds [3];
    logic       rs;
    logic       et;
    rs = reset;
    for (int k = 0; k < 3; k++) begin
      acc[k] = vin[k] & rdy[k] & ~reset;
      ds[k]  = din[k];
    end
    @(posedge clk);
    #1;
    last_acc = acc;
    for (int k = 0; k < 3; k++) begin
      if (rs) begin
        act[k] = 1'b0;
        hd[k]  = 0;
        tl[k]  = 0;
      end else begin
        if (act[k]) begin
          pos[k]++;
          if (pos[k] == nbits[k] * DIVT) act[k] = 1'b0;
        end
        if (!act[k] && tl[k] > hd[k]) begin
          fbits[k] = mk_frame(k, fq[k][hd[k] % 64]);
          hd[k]++;
          pos[k] = 0;
          act[k] = 1'b1;
        end
        if (acc[k]) begin
          fq[k][tl[k] % 64] = ds[k];
          tl[k]++;
        end
      end
      et = act[k] ? fbits[k][pos[k] / DIVT] : 1'b1;
      chk("txd", k, 8'(txd[k]), 8'(et));
      chk("fifo_count", k, 8'(cnt[k]), 8'(tl[k] - hd[k]));
      chk("busy", k, 8'(busy[k]), 8'(act[k] || (tl[k] > hd[k])));
      chk("in_ready", k, 8'(rdy[k]), 8'((tl[k] - hd[k]) != 16));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int k, input logic [7:0] b);
    int n;
    n = 0;
    din[k] = b;
    vin[k] = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_acc[k] && n < 5000);
    chk("accept_timeout", k, 8'(last_acc[k]), 8'd1);
    vin[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 20000) begin
      tick();
      n++;
      idle = 1'b1;
      for (int k = 0; k < 3; k++)
        if (act[k] || tl[k] > hd[k]) idle = 1'b0;
    end
    chk("idle_timeout", 0, 8'(idle), 8'd1);
    ticks(3);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    vin   = '0;
    for (int k = 0; k < 3; k++) begin
      din[k] = '0;
      hd[k] = 0; tl[k] = 0; act[k] = 1'b0; pos[k] = 0; fbits[k] = '1;
    end
    last_acc = '0;

    // Reset values
    ticks(3);
    reset = 1'b0;
    ticks(2);

    // 8N1 single byte, then 8E1 and 8O2 with 0x07 (parity 1 / 0)
    send(0, 8'h55);
    ticks(120);
    send(1, 8'h07);
    send(2, 8'h07);
    wait_idle();

    // Streamed 20 bytes through 8N1: FIFO fills, frames chain with no gap
    for (int i = 0; i < 20; i++) send(0, 8'(i));
    wait_idle();

    // Two stop bits between 0xFF and 0x00
    send(2, 8'hFF);
    send(2, 8'h00);
    wait_idle();

    // Push coinciding with the stop-end pop at occupancy 15
    for (int i = 0; i < 16; i++) send(0, 8'h80 + 8'(i));
    chk("pre_fill", 0, 8'(cnt[0]), 8'd15);
    n = 0;
    while (!(act[0] && pos[0] == nbits[0] * DIVT - 1) && n < 500) begin
      tick();
      n++;
    end
    chk("stop_end_timeout", 0, 8'(n < 500), 8'd1);
    din[0] = 8'hC0;
    vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    chk("pushpop_acc", 0, 8'(last_acc[0]), 8'd1);
    chk("pushpop_cnt", 0, 8'(cnt[0]), 8'd15);
    chk("pushpop_rdy", 0, 8'(rdy[0]), 8'd1);
    wait_idle();

    // Reset in the middle of the data bits of 0xA3 with three bytes queued
    send(0, 8'hA3);
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    n = 0;
    while (!(act[0] && pos[0] == 45) && n < 500) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    chk("rst_txd", 0, 8'(txd[0]), 8'd1);
    chk("rst_cnt", 0, 8'(cnt[0]), 8'd0);
    chk("rst_rdy", 0, 8'(rdy[0]), 8'd1);
    chk("rst_busy", 0, 8'(busy[0]), 8'd0);
    reset = 1'b0;
    ticks(300);

    // Random bytes with random gaps across all three instances
    for (int r = 0; r < 30; r++) begin
      int k;
      k = int'($urandom_range(0, 2));
      ticks(int'($urandom_range(0, 120)));
      send(k, 8'($urandom));
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
